read_fifo_ctrl_gray: RTL and testbench

Next-generation read-side controller for the asynchronous FIFO. It replaces the plain binary read pointer with an (ADDR_WIDTH+1)-bit binary/Gray pointer pair and synchronises the incoming write Gray pointer through a parametrised flop chain. It adds fill-level, almost-empty and underflow reporting. It sits in the read clock domain between the dual-port RAM read address and the write-domain controller, which consumes r_gray_ptr_out.

---
 rtl/read_fifo_ctrl_gray.sv | 87 ++++++++
 tb/tb_read_fifo_ctrl_gray.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/read_fifo_ctrl_gray.sv
// Read-side controller for an asynchronous FIFO: binary/Gray read pointer, write-pointer synchroniser, level/empty/almost-empty flags.
// Optional sticky underflow detection is built when RFIFO_UNDERFLOW_EN is defined; otherwise r_underflow_out is tied low.
module read_fifo_ctrl_gray #(
  parameter int ADDR_WIDTH          = 3,
  parameter int SYNC_STAGES         = 2,
  parameter int ALMOST_EMPTY_THRESH = 1
) (
  input  logic                  r_clk_in,
  input  logic                  r_reset_n_in,
  input  logic                  r_request_in,
  input  logic [ADDR_WIDTH:0]   w_gray_ptr_in,
  output logic [ADDR_WIDTH:0]   r_gray_ptr_out,
  output logic [ADDR_WIDTH-1:0] r_addr_out,
  output logic                  r_read_en_out,
  output logic                  r_empty_out,
  output logic                  r_almost_empty_out,
  output logic [ADDR_WIDTH:0]   r_level_out,
  output logic                  r_underflow_out
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] THRESH = PW'(ALMOST_EMPTY_THRESH);

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_bin_next;
  logic [PW-1:0] r_gray_next;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] w_gray_sync;
  logic [PW-1:0] w_bin_sync;
  logic [PW-1:0] level_next;

  // Request/grant: a read is granted in the same cycle r_request_in is high
  // and the registered empty flag is low; ungranted requests are dropped.
  assign r_read_en_out = r_request_in & ~r_empty_out;

  assign r_bin_next  = r_bin + {{ADDR_WIDTH{1'b0}}, r_read_en_out};
  assign r_gray_next = r_bin_next ^ (r_bin_next >> 1);
  assign r_addr_out  = r_bin[ADDR_WIDTH-1:0];

  // Plain flop chain; the intermediate stages feed nothing but the next stage.
  always_ff @(posedge r_clk_in or negedge r_reset_n_in) begin
    if (!r_reset_n_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= w_gray_ptr_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign w_gray_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    w_bin_sync = '0;
    for (int i = 0; i < PW; i++) w_bin_sync[i] = ^(w_gray_sync >> i);
  end

  // Modulo subtraction keeps full (equal addresses, differing MSB) at 2**ADDR_WIDTH.
  assign level_next = w_bin_sync - r_bin_next;

  always_ff @(posedge r_clk_in or negedge r_reset_n_in) begin
    if (!r_reset_n_in) begin
      r_bin              <= '0;
      r_gray_ptr_out     <= '0;
      r_empty_out        <= 1'b1;
      r_almost_empty_out <= 1'b1;
      r_level_out        <= '0;
    end else begin
      r_bin              <= r_bin_next;
      r_gray_ptr_out     <= r_gray_next;
      r_empty_out        <= (r_gray_next == w_gray_sync);
      r_almost_empty_out <= (level_next <= THRESH);
      r_level_out        <= level_next;
    end
  end

`ifdef RFIFO_UNDERFLOW_EN
  always_ff @(posedge r_clk_in or negedge r_reset_n_in) begin
    if (!r_reset_n_in) begin
      r_underflow_out <= 1'b0;
    end else if (r_request_in && r_empty_out) begin
      r_underflow_out <= 1'b1;
    end
  end
`else
  assign r_underflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_read_fifo_ctrl_gray.sv
// Bench for read_fifo_ctrl_gray: queue-based occupancy model checked every cycle plus literal spot checks.
module tb_read_fifo_ctrl_gray;
  localparam int AW = 3;
  localparam int PW = AW + 1;
  localparam int SS = 2;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic [PW-1:0] wbin;
  logic [PW-1:0] w_gray;
  logic [PW-1:0] gray;
  logic [AW-1:0] addr;
  logic          read_en;
  logic          empty;
  logic          almost;
  logic [PW-1:0] level;
  logic          underflow;

  int checks;
  int failures;

  assign w_gray = wbin ^ (wbin >> 1);

  read_fifo_ctrl_gray #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .ALMOST_EMPTY_THRESH(1)) dut (
    .r_clk_in(clk),
    .r_reset_n_in(rst_n),
    .r_request_in(req),
    .w_gray_ptr_in(w_gray),
    .r_gray_ptr_out(gray),
    .r_addr_out(addr),
    .r_read_en_out(read_en),
    .r_empty_out(empty),
    .r_almost_empty_out(almost),
    .r_level_out(level),
    .r_underflow_out(underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: read count, and the write count seen through the synchroniser delay
  logic [PW-1:0] m_rd;
  logic [PW-1:0] m_level;
  logic          m_empty;
  logic          m_almost;
  logic          m_uf;
  logic [PW-1:0] m_wq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd     <= '0;
      m_level  <= '0;
      m_empty  <= 1'b1;
      m_almost <= 1'b1;
      m_uf     <= 1'b0;
      m_wq = {};
      for (int i = 0; i < SS; i++) m_wq.push_back('0);
    end else begin
      automatic logic [PW-1:0] wseen = m_wq.pop_front();
      automatic logic [PW-1:0] nrd = m_rd + ((req && m_empty == 1'b0) ? 4'd1 : 4'd0);
      automatic logic [PW-1:0] lvl = wseen - nrd;
      m_wq.push_back(wbin);
      m_rd     <= nrd;
      m_level  <= lvl;
      m_empty  <= (lvl == 0);
      m_almost <= (lvl <= 1);
      if (req && m_empty) m_uf <= 1'b1;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic [PW-1:0] exp_gray = m_rd ^ (m_rd >> 1);
      check("cyc_empty", empty, m_empty);
      check("cyc_level", level, m_level);
      check("cyc_almost", almost, m_almost);
      check("cyc_addr", addr, m_rd[AW-1:0]);
      check("cyc_gray", gray, exp_gray);
      check("cyc_read_en", read_en, req & ~m_empty);
`ifdef RFIFO_UNDERFLOW_EN
      check("cyc_underflow", underflow, m_uf);
`else
      check("cyc_underflow", underflow, 1'b0);
`endif
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_almost"}, almost, 1);
    check({tag, "_level"}, level, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_gray"}, gray, 0);
    check({tag, "_underflow"}, underflow, 0);
  endtask

  logic [PW-1:0] gtbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0111, 4'b0101, 4'b0100, 4'b1100};

  initial begin
    checks = 0;
    failures = 0;
    req = 1'b0;
    wbin = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // reset held
    tick(3);
    check_reset_values("rst_hold");
    rst_n = 1'b1;
    tick(2);

    // write pointer 0 -> 1: visible three edges later
    wbin = 4'd1;
    tick(1);
    check("lat1_empty_e1", empty, 1);
    tick(1);
    check("lat1_empty_e2", empty, 1);
    tick(1);
    check("lat1_empty_e3", empty, 0);
    check("lat1_level_e3", level, 1);
    check("lat1_almost_e3", almost, 1);
    wbin = 4'd2;
    tick(2);
    check("lat2_level_e2", level, 1);
    tick(1);
    check("lat2_level_e3", level, 2);
    check("lat2_almost_e3", almost, 0);

    // full: write pointer 8, addresses equal
    wbin = 4'd8;
    tick(3);
    check("full_level", level, 8);
    check("full_empty", empty, 0);
    check("full_addr", addr, 0);

    // eight back-to-back reads
    req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_addr", addr, i);
      check("drain_read_en", read_en, 1);
      tick(1);
      check("drain_gray", gray, gtbl[i]);
    end
    check("drain_empty", empty, 1);
    check("drain_level", level, 0);
    req = 1'b0;
    tick(1);

    // requests while empty
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("uf_read_en", read_en, 0);
      tick(1);
      check("uf_addr", addr, 0);
      check("uf_gray", gray, 4'b1100);
`ifdef RFIFO_UNDERFLOW_EN
      check("uf_flag", underflow, 1);
`else
      check("uf_flag", underflow, 0);
`endif
    end
    req = 1'b0;

    // level 5, then asynchronous reset between edges
    wbin = 4'd13;
    tick(3);
    check("pre_rst_level", level, 5);
    #3;
    rst_n = 1'b0;
    wbin = '0;
    #1;
    check_reset_values("rst_async");
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // wrap: four bursts of four writes then a read burst
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        wbin = wbin + 4'd1;
        tick(1);
      end
      req = 1'b1;
      tick(8);
      req = 1'b0;
      tick(1);
    end
    check("wrap_gray", gray, 0);
    check("wrap_addr", addr, 0);
    check("wrap_empty", empty, 1);
    check("wrap_level", level, 0);

    // last entry read on the same edge the write pointer advances
    wbin = wbin + 4'd1;
    tick(3);
    check("race_pre_level", level, 1);
    req = 1'b1;
    wbin = wbin + 4'd1;
    #1;
    check("race_read_en", read_en, 1);
    tick(1);
    req = 1'b0;
    check("race_empty_e1", empty, 1);
    check("race_level_e1", level, 0);
    tick(1);
    check("race_empty_e2", empty, 1);
    tick(1);
    check("race_empty_e3", empty, 0);
    check("race_level_e3", level, 1);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
